// File: rtl/pipeline_elastic_chain_pkg.sv
// Shared defaults and a constant clog2 helper for the elastic pipeline chain.
package pipeline_elastic_chain_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_STAGES = 5;
  localparam int unsigned DEF_CNT_W  = 32;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 1) ? value - 1 : 0;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipeline_stage_slot.sv
// One valid+payload register stage; kill overrides advance, payload is not reset.
module pipeline_stage_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              kill,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              valid,
  output logic              valid_next,
  output logic [DATA_W-1:0] data
);

  logic              valid_q;
  logic [DATA_W-1:0] data_q;

  always_comb begin
    valid_next = valid_q;
    if (kill) begin
      valid_next = 1'b0;
    end else if (advance) begin
      valid_next = up_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_next;
    end
  end

  // Bubbles and squashed entries leave the payload untouched.
  always_ff @(posedge clk) begin
    if (advance && up_valid && !kill) begin
      data_q <= up_data;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipeline_elastic_chain.sv
// Elastic register chain with combinational ready propagation, partial flush and
// saturating transfer/flush statistics.
module pipeline_elastic_chain
  import pipeline_elastic_chain_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned CNT_W  = DEF_CNT_W,
  localparam int unsigned OCC_W = clog2(STAGES + 1)
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              in_ready,
  input  logic              in_flush,
  input  logic [OCC_W-1:0]  in_flush_depth,
  output logic [OCC_W-1:0]  out_occupancy,
  output logic [CNT_W-1:0]  out_accept_count,
  output logic [CNT_W-1:0]  out_flush_count
);

  logic [STAGES-1:0] stage_valid;
  logic [STAGES-1:0] stage_valid_next;
  logic [STAGES-1:0] stage_kill;
  logic [STAGES-1:0] stage_load;
  logic [STAGES-1:0] up_valid;
  logic [DATA_W-1:0] stage_data [STAGES];
  logic [STAGES:0]   ready_chain;

  logic [OCC_W-1:0]  flush_n;
  logic              flush_all;
  logic              out_fire;
  logic [OCC_W-1:0]  squash_cnt;
  logic [OCC_W-1:0]  occ_d, occ_q;
  logic [CNT_W:0]    accept_sum, flush_sum;
  logic [CNT_W-1:0]  accept_cnt_d, accept_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_d, flush_cnt_q;

  always_comb begin
    flush_n = '0;
    if (in_flush) begin
      flush_n = (in_flush_depth > OCC_W'(STAGES)) ? OCC_W'(STAGES) : in_flush_depth;
    end
  end

  // A whole-chain flush also blocks the output so nothing escapes the squash.
  assign flush_all = (flush_n == OCC_W'(STAGES));

  always_comb begin
    ready_chain         = '0;
    ready_chain[STAGES] = in_ready & ~flush_all;
    for (int i = STAGES - 1; i >= 0; i--) begin
      ready_chain[i] = ~stage_valid[i] | ready_chain[i+1];
    end
  end

  assign out_in_ready = ready_chain[0] & ~in_rst & (flush_n == '0);

  // Entries leaving a squashed stage become bubbles in the next stage.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      stage_kill[i] = (int'(flush_n) > i);
      stage_load[i] = ready_chain[i];
    end
    up_valid[0] = in_valid & out_in_ready;
    for (int i = 1; i < STAGES; i++) begin
      up_valid[i] = stage_valid[i-1] & ~stage_kill[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [DATA_W-1:0] up_data;
    if (g == 0) begin : g_head
      assign up_data = in_data;
    end else begin : g_body
      assign up_data = stage_data[g-1];
    end

    pipeline_stage_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk       (in_clk),
      .rst       (in_rst),
      .advance   (stage_load[g]),
      .kill      (stage_kill[g]),
      .up_valid  (up_valid[g]),
      .up_data   (up_data),
      .valid     (stage_valid[g]),
      .valid_next(stage_valid_next[g]),
      .data      (stage_data[g])
    );
  end

  assign out_valid = stage_valid[STAGES-1] & ~flush_all;
  assign out_data  = stage_data[STAGES-1];
  assign out_fire  = out_valid & in_ready;

  always_comb begin
    squash_cnt = '0;
    occ_d      = '0;
    for (int i = 0; i < STAGES; i++) begin
      squash_cnt = squash_cnt + OCC_W'(stage_valid[i] & stage_kill[i]);
      occ_d      = occ_d + OCC_W'(stage_valid_next[i]);
    end
    accept_sum   = {1'b0, accept_cnt_q} + (CNT_W + 1)'(out_fire);
    accept_cnt_d = accept_sum[CNT_W] ? '1 : accept_sum[CNT_W-1:0];
    flush_sum    = {1'b0, flush_cnt_q} + (CNT_W + 1)'(squash_cnt);
    flush_cnt_d  = flush_sum[CNT_W] ? '1 : flush_sum[CNT_W-1:0];
  end

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      occ_q        <= '0;
      accept_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      occ_q        <= occ_d;
      accept_cnt_q <= accept_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign out_occupancy    = occ_q;
  assign out_accept_count = accept_cnt_q;
  assign out_flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_elastic_chain.sv
// Directed per-cycle vector bench for pipeline_elastic_chain at default parameters.
module tb_pipeline_elastic_chain;

  logic        in_clk;
  logic        in_rst;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        in_ready;
  logic        in_flush;
  logic [2:0]  in_flush_depth;
  logic [2:0]  out_occupancy;
  logic [31:0] out_accept_count;
  logic [31:0] out_flush_count;

  int total;
  int bad;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ir;
    logic        fl;
    logic [2:0]  fd;
    logic        rst;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_od;
    logic [2:0]  e_occ;
  } vec_t;

  vec_t vecs[$];

  pipeline_elastic_chain dut (
    .in_clk          (in_clk),
    .in_rst          (in_rst),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .out_in_ready    (out_in_ready),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .in_ready        (in_ready),
    .in_flush        (in_flush),
    .in_flush_depth  (in_flush_depth),
    .out_occupancy   (out_occupancy),
    .out_accept_count(out_accept_count),
    .out_flush_count (out_flush_count)
  );

  initial in_clk = 1'b0;
  always #5 in_clk = ~in_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] id, input logic ir, input logic fl,
                     input logic [2:0] fd, input logic rst, input logic e_rdy, input logic e_ov,
                     input logic [31:0] e_od, input logic [2:0] e_occ);
    vec_t v;
    v.iv = iv; v.id = id; v.ir = ir; v.fl = fl; v.fd = fd; v.rst = rst;
    v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_od = e_od; v.e_occ = e_occ;
    vecs.push_back(v);
  endtask

  // Fill an empty chain with n items while downstream stalls.
  task automatic add_fill(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      add(1'b1, base + 32'(k + 1), 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 3'(k));
    end
  endtask

  task automatic idle();
    in_valid = 1'b0; in_data = '0; in_ready = 1'b1;
    in_flush = 1'b0; in_flush_depth = '0; in_rst = 1'b0;
  endtask

  task automatic run_vectors(input string tag);
    for (int k = 0; k < vecs.size(); k++) begin
      in_valid = vecs[k].iv; in_data = vecs[k].id; in_ready = vecs[k].ir;
      in_flush = vecs[k].fl; in_flush_depth = vecs[k].fd; in_rst = vecs[k].rst;
      @(negedge in_clk);
      check($sformatf("%s[%0d].in_ready", tag, k), 64'(out_in_ready), 64'(vecs[k].e_rdy));
      check($sformatf("%s[%0d].valid", tag, k), 64'(out_valid), 64'(vecs[k].e_ov));
      check($sformatf("%s[%0d].occ", tag, k), 64'(out_occupancy), 64'(vecs[k].e_occ));
      if (vecs[k].e_ov) begin
        check($sformatf("%s[%0d].data", tag, k), 64'(out_data), 64'(vecs[k].e_od));
      end
      @(posedge in_clk); #1;
    end
    vecs.delete();
    idle();
  endtask

  task automatic check_counts(input string tag, input int acc, input int fls);
    @(negedge in_clk);
    check({tag, ".accept"}, 64'(out_accept_count), 64'(acc));
    check({tag, ".flush"}, 64'(out_flush_count), 64'(fls));
    @(posedge in_clk); #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    idle();
    in_rst = 1'b1;
    repeat (2) @(posedge in_clk);
    #1;
    @(negedge in_clk);
    check("rst.in_ready", 64'(out_in_ready), 64'(0));
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    @(negedge in_clk);
    check("rst.valid", 64'(out_valid), 64'(0));
    check("rst.occ", 64'(out_occupancy), 64'(0));
    check("rst.accept", 64'(out_accept_count), 64'(0));
    check("rst.flush", 64'(out_flush_count), 64'(0));
    @(posedge in_clk); #1;

    // Single-item latency, then stalled fill, depth-0 flush, release and drain.
    add(1'b1, 32'hDEADBEEF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0);
    for (int k = 1; k < 5; k++) add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd1);
    add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 3'd1);
    add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0);
    add_fill(32'hA000_0000, 5);
    add(1'b1, 32'hA000_0006, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 32'hA000_0001, 3'd5);
    add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 32'hA000_0001, 3'd5);
    for (int k = 2; k <= 5; k++) begin
      add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 32'hA000_0000 + 32'(k), 3'(6 - k));
    end
    add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0);
    run_vectors("single_fill");
    check_counts("single_fill", 6, 0);

    // Back-to-back stream of 20 items.
    for (int t = 0; t < 27; t++) begin
      int n_in;
      int n_out;
      logic exp_ov;
      in_valid = (t < 20);
      in_data  = 32'hB000_0000 + 32'(t);
      in_ready = 1'b1;
      n_in   = (t < 20) ? t : 20;
      n_out  = (t < 5) ? 0 : ((t - 5 < 20) ? t - 5 : 20);
      exp_ov = (t >= 5) && (t < 25);
      @(negedge in_clk);
      check($sformatf("stream[%0d].in_ready", t), 64'(out_in_ready), 64'(1));
      check($sformatf("stream[%0d].valid", t), 64'(out_valid), 64'(exp_ov));
      check($sformatf("stream[%0d].occ", t), 64'(out_occupancy), 64'(n_in - n_out));
      if (exp_ov) begin
        check($sformatf("stream[%0d].data", t), 64'(out_data), 64'(32'hB000_0000 + 32'(t - 5)));
      end
      @(posedge in_clk); #1;
    end
    idle();
    check_counts("stream", 26, 0);

    // Depth-3 flush of a stalled full chain.
    add_fill(32'hC000_0000, 5);
    add(1'b1, 32'hC000_0006, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b1, 32'hC000_0001, 3'd5);
    add(1'b0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 32'hC000_0001, 3'd2);
    add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 32'hC000_0001, 3'd2);
    add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 32'hC000_0002, 3'd1);
    add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0);
    run_vectors("flush3");
    check_counts("flush3", 28, 3);

    // Oversized depth squashes everything and blocks the output that cycle.
    add_fill(32'hD000_0000, 5);
    add(1'b1, 32'hD000_0006, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0, 1'b0, 32'h0, 3'd5);
    add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0);
    run_vectors("flush7");
    check_counts("flush7", 28, 8);

    // Depth-2 flush while draining: upper stages advance, stage 2 gets a bubble.
    add_fill(32'hE000_0000, 5);
    add(1'b1, 32'hE000_0006, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 32'hE000_0001, 3'd5);
    add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 32'hE000_0002, 3'd2);
    add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 32'hE000_0003, 3'd1);
    add(1'b0, 32'h0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 32'h0, 3'd0);
    run_vectors("flush2");
    check_counts("flush2", 31, 10);

    // Reset with four items in flight.
    add_fill(32'hF000_0000, 4);
    add(1'b1, 32'hF000_0005, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 32'h0, 3'd4);
    run_vectors("midrst");
    @(negedge in_clk);
    check("midrst.valid", 64'(out_valid), 64'(0));
    check("midrst.occ", 64'(out_occupancy), 64'(0));
    check("midrst.accept", 64'(out_accept_count), 64'(0));
    check("midrst.flush", 64'(out_flush_count), 64'(0));
    @(posedge in_clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_elastic_chain.md
PIPELINE_ELASTIC_CHAIN -- requirements
Module: pipeline_elastic_chain

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the payload width per stage.
REQ-002 Parameter STAGES, default 5, range 2..16, SHALL set the number of register stages; stage 0 is youngest, STAGES-1 is oldest.
REQ-003 Parameter CNT_W, default 32, SHALL set the width of the statistics counters.
REQ-004 Localparam OCC_W SHALL equal clog2(STAGES+1).
REQ-005 Port in_clk, input, 1, is the single clock; all state SHALL update on its rising edge.
REQ-006 Port in_rst, input, 1, is the reset; it SHALL be synchronous and active-high.
REQ-007 in_valid, input, 1: upstream offers in_data.
REQ-008 in_data, input, DATA_W: upstream payload.
REQ-009 out_in_ready, output, 1: chain accepts in_data this cycle.
REQ-010 out_valid, output, 1: oldest stage presents out_data.
REQ-011 out_data, output, DATA_W: payload of stage STAGES-1.
REQ-012 in_ready, input, 1: downstream accepts out_data.
REQ-013 in_flush, input, 1: squash request.
REQ-014 in_flush_depth, input, OCC_W: number of youngest stages squashed; values above STAGES SHALL be treated as STAGES.
REQ-015 out_occupancy, output, OCC_W: count of valid stages.
REQ-016 out_accept_count, output, CNT_W: completed output transfers.
REQ-017 out_flush_count, output, CNT_W: valid entries destroyed by flushes.

Function
REQ-018 Each stage SHALL hold a valid bit and a DATA_W payload; a stage SHALL advance when the next stage is empty or advancing; stage STAGES-1 advances when out_valid and in_ready.
REQ-019 Readiness SHALL propagate combinationally from in_ready to out_in_ready, so an empty stage absorbs a bubble and full throughput of 1 item per cycle is sustained.
REQ-020 Input transfer SHALL occur when in_valid and out_in_ready are both 1; output transfer SHALL occur when out_valid and in_ready are both 1.
REQ-021 Latency through an empty, unstalled chain SHALL be exactly STAGES cycles from input transfer to out_valid.
REQ-022 A stage that neither advances nor is squashed SHALL hold its payload and valid bit unchanged.
REQ-023 A flush with depth N SHALL clear the valid bits of stages 0..N-1 as they stood at the start of the cycle; an item leaving stage N-1 that cycle SHALL be destroyed, and stage N SHALL receive a bubble.
REQ-024 While in_flush is 1 and N>0, out_in_ready SHALL be 0.
REQ-025 A flush with N=0 SHALL have no effect.
REQ-026 If N>=STAGES, out_valid SHALL be forced to 0 that cycle and no output transfer SHALL occur.
REQ-027 Stages at or above N SHALL advance normally during a flush.
REQ-028 out_flush_count SHALL increase by the popcount of squashed valid entries.
REQ-029 out_accept_count SHALL increment by 1 per output transfer.
REQ-030 Both counters SHALL saturate at all-ones.
REQ-031 out_occupancy SHALL be the registered popcount of stage valid bits.

Reset
REQ-032 On in_rst, all valid bits SHALL clear; out_valid, out_occupancy, out_accept_count and out_flush_count SHALL be 0 at the next edge.
REQ-033 Payload registers need not be reset; out_data SHALL be don't-care while out_valid is 0.
REQ-034 Reset asserted mid-transfer SHALL discard all in-flight items without counting them as flushed.
REQ-035 out_in_ready SHALL be 0 while in_rst is 1.

Structure
REQ-036 The default DATA_W, STAGES and CNT_W values and a clog2 constant function SHALL reside in the shared pipeline package.
REQ-037 One sub-module, pipeline_stage_slot, SHALL implement a single valid+payload stage with advance and kill inputs, instantiated STAGES times via generate.

Verification
REQ-038 Empty chain, STAGES=5, in_ready=1, a single item 0xDEADBEEF at cycle 0 -> out_valid=1 with out_data=0xDEADBEEF at cycle 5 only; out_accept_count=1.
REQ-039 Stream of 20 consecutive items, in_ready=1 -> 20 back-to-back outputs in order, no gaps; out_occupancy=5 in steady state.
REQ-040 Fill 5 items with in_ready=0 -> out_in_ready=0 after the 5th; release in_ready -> out_in_ready=1 in the same cycle; outputs appear in order.
REQ-041 Full chain, in_ready=0, flush with depth 3 -> stages 0..2 cleared; out_flush_count=3; out_occupancy=2; the remaining 2 items are delivered in order.
REQ-042 Flush with depth 7 while in_ready=1 and the chain is full -> out_valid=0 that cycle; out_flush_count=5; out_accept_count unchanged.
REQ-043 in_rst asserted while the chain holds 4 items -> all outputs 0 at the next edge; out_flush_count stays 0.
